// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the multi-channel frequency divider.
//   MIN_DIV      - smallest effective divisor (fastest output is clk/2)
//   MODE_SQUARE  - channel mode value for a square-wave output
//   MODE_PULSE   - channel mode value for a one-cycle-per-period pulse
//   DIV_W_DEF    - default divisor/counter width
//   clamp_div()  - returns max(d, MIN_DIV); operates on 32 bits, so DIV_W <= 32
package freq_div_pkg;

    localparam int unsigned DIV_W_DEF   = 25;
    localparam int unsigned MIN_DIV     = 2;
    localparam logic        MODE_SQUARE = 1'b0;
    localparam logic        MODE_PULSE  = 1'b1;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: divisor register, period counter and registered outputs.
// Ports:
//   i_clk, i_rst  - system clock, synchronous active-high reset
//   i_en          - count enable (tick forced low while disabled)
//   i_mode        - MODE_SQUARE or MODE_PULSE
//   i_load        - single-cycle strobe capturing i_div_val, restarts the period
//   i_div_val     - divisor, sampled only on i_load
//   o_clk_out     - divided waveform (a data signal, not a clock)
//   o_tick        - one-cycle pulse in the last cycle of each period
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = 27_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div_val,
    output logic             o_clk_out,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_clk_out;
    logic             r_tick;

    logic [DIV_W-1:0] w_d;
    logic [DIV_W-1:0] w_d_last;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_wrap;
    logic             w_nxt_last;

    assign w_d        = DIV_W'(clamp_div(32'(r_div)));
    assign w_d_last   = w_d - DIV_W'(1);
    assign w_half     = w_d >> 1;
    // >= rather than == so an out-of-range count can never run away
    assign w_wrap     = (r_cnt >= w_d_last);
    assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + DIV_W'(1);
    assign w_nxt_last = (w_cnt_nxt == w_d_last);

    // Outputs decode the next count so they line up with r_cnt with no lag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_div     <= DIV_W'(DEFAULT_DIV);
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_load) begin
            r_div     <= i_div_val;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_en) begin
            r_cnt     <= w_cnt_nxt;
            r_tick    <= w_nxt_last;
            r_clk_out <= (i_mode == MODE_PULSE) ? w_nxt_last : (w_cnt_nxt >= w_half);
        end else begin
            r_tick    <= 1'b0;
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule

// File: rtl/module_freq_div_multi.sv
// Multi-channel programmable clock-enable divider. Each channel is independent;
// this level only slices the buses onto freq_div_channel instances.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   en         - per-channel count enable
//   mode       - per-channel mode (0 square, 1 pulse)
//   load       - per-channel divisor load strobe
//   div_val    - channel i divisor at [i*DIV_W +: DIV_W]
//   clk_out    - per-channel divided waveform (registered)
//   tick       - per-channel end-of-period pulse (registered)
module module_freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27_000_000,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = CLK_FREQ_HZ / 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       mode,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH*DIV_W-1:0] div_val,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        freq_div_channel #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_en     (en[g]),
            .i_mode   (mode[g]),
            .i_load   (load[g]),
            .i_div_val(div_val[g*DIV_W +: DIV_W]),
            .o_clk_out(clk_out[g]),
            .o_tick   (tick[g])
        );
    end

endmodule

// File: tb/tb_module_freq_div_multi.sv
module tb_module_freq_div_multi;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned DIV_W = 25;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       mode;
    logic [N_CH-1:0]       load;
    logic [N_CH*DIV_W-1:0] div_val;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    module_freq_div_multi #(
        .CLK_FREQ_HZ(27_000_000),
        .N_CH       (N_CH),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(27_000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .load   (load),
        .div_val(div_val),
        .clk_out(clk_out),
        .tick   (tick)
    );

    // Pattern bit [i] is the value sampled i cycles after the load edge
    typedef struct {
        int              ch;
        logic [DIV_W-1:0] dv;
        logic            md;
        logic [0:11]     exp_clk;
        logic [0:11]     exp_tick;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_div(input int ch, input logic [DIV_W-1:0] v);
        div_val[ch*DIV_W +: DIV_W] = v;
    endtask

    initial begin
        int c0, e1, t1;
        int cnt_t[2];
        int first_t[2];
        int last_t[2];
        logic [0:5] seq_clk;
        logic [0:5] seq_tick;

        vecs[0] = '{0, 25'd4, 1'b0, 12'b001100110011, 12'b000100010001};
        vecs[1] = '{1, 25'd5, 1'b0, 12'b001110011100, 12'b000010000100};
        vecs[2] = '{1, 25'd5, 1'b1, 12'b000010000100, 12'b000010000100};
        vecs[3] = '{0, 25'd0, 1'b0, 12'b010101010101, 12'b010101010101};
        vecs[4] = '{0, 25'd1, 1'b0, 12'b010101010101, 12'b010101010101};
        vecs[5] = '{1, 25'd1, 1'b1, 12'b010101010101, 12'b010101010101};
        vecs[6] = '{0, 25'd3, 1'b1, 12'b001001001001, 12'b001001001001};

        rst = 1'b1; en = '0; mode = '0; load = '0; div_val = '0;
        step();
        step();
        chk("reset clk_out", int'(clk_out), 0);
        chk("reset tick", int'(tick), 0);
        rst = 1'b0;

        // Table-driven: load, then compare 12 cycles of each waveform
        for (int v = 0; v < 7; v++) begin
            en = 2'b11;
            load = '0;
            mode[vecs[v].ch] = vecs[v].md;
            set_div(vecs[v].ch, vecs[v].dv);
            load[vecs[v].ch] = 1'b1;
            step();
            load = '0;
            for (int i = 0; i < 12; i++) begin
                if (i > 0) step();
                chk($sformatf("vec%0d cyc%0d clk_out", v, i), int'(clk_out[vecs[v].ch]),
                    int'(vecs[v].exp_clk[i]));
                chk($sformatf("vec%0d cyc%0d tick", v, i), int'(tick[vecs[v].ch]),
                    int'(vecs[v].exp_tick[i]));
            end
        end

        // Reload mid-period: D=10 run to cnt=7, then load D=6
        mode = '0; en = 2'b11;
        set_div(0, 25'd10); load[0] = 1'b1; step(); load = '0;
        repeat (7) step();
        chk("D10 cnt7 clk_out", int'(clk_out[0]), 1);
        chk("D10 cnt7 tick", int'(tick[0]), 0);
        set_div(0, 25'd6); load[0] = 1'b1; step(); load = '0;
        chk("reload clk_out", int'(clk_out[0]), 0);
        chk("reload tick", int'(tick[0]), 0);
        seq_clk  = 6'b001110;
        seq_tick = 6'b000010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("D6 cyc%0d clk_out", i + 1), int'(clk_out[0]), int'(seq_clk[i]));
            chk($sformatf("D6 cyc%0d tick", i + 1), int'(tick[0]), int'(seq_tick[i]));
        end

        // Enable drop at cnt=3 freezes outputs; drop at cnt=D-1 clears tick
        repeat (3) step();
        chk("D6 cnt3 clk_out", int'(clk_out[0]), 1);
        en[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("hold%0d clk_out", i), int'(clk_out[0]), 1);
            chk($sformatf("hold%0d tick", i), int'(tick[0]), 0);
        end
        en[0] = 1'b1;
        step();
        chk("resume cnt4 clk_out", int'(clk_out[0]), 1);
        chk("resume cnt4 tick", int'(tick[0]), 0);
        step();
        chk("resume cnt5 tick", int'(tick[0]), 1);
        en[0] = 1'b0;
        step();
        chk("disabled tick cleared", int'(tick[0]), 0);
        chk("disabled clk_out held", int'(clk_out[0]), 1);
        en[0] = 1'b1;
        step();
        chk("wrap clk_out", int'(clk_out[0]), 0);
        chk("wrap tick", int'(tick[0]), 0);

        // Independence: ch0 D=3 free-running, ch1 D=7 with gated enable
        mode = '0; en = 2'b11;
        set_div(0, 25'd3); set_div(1, 25'd7); load = 2'b11; step(); load = '0;
        c0 = 0; e1 = 0; t1 = 0;
        for (int i = 0; i < 70; i++) begin
            en[1] = ((i % 3) != 0);
            step();
            c0 = (c0 + 1) % 3;
            if (en[1]) e1++;
            chk($sformatf("indep ch0 cyc%0d clk_out", i), int'(clk_out[0]), int'(c0 >= 1));
            chk($sformatf("indep ch0 cyc%0d tick", i), int'(tick[0]), int'(c0 == 2));
            if (tick[1]) t1++;
        end
        chk("indep ch1 tick count", t1, (e1 + 1) / 7);

        // Reset mid-period overrides load and en
        en = 2'b11;
        set_div(0, 25'd10); load[0] = 1'b1; step(); load = '0;
        repeat (8) step();
        chk("D10 cnt8 clk_out", int'(clk_out[0]), 1);
        rst = 1'b1; load = 2'b11; set_div(0, 25'd4); set_div(1, 25'd4);
        step();
        rst = 1'b0; load = '0;
        chk("mid reset clk_out", int'(clk_out), 0);
        chk("mid reset tick", int'(tick), 0);

        // 3 ms at 27 MHz on the reset divisor of 27000
        for (int c = 0; c < 2; c++) begin
            cnt_t[c] = 0; first_t[c] = -1; last_t[c] = -1;
        end
        for (int k = 1; k <= 81_000; k++) begin
            step();
            for (int c = 0; c < 2; c++) begin
                if (tick[c]) begin
                    if (first_t[c] < 0) first_t[c] = k;
                    last_t[c] = k;
                    cnt_t[c]++;
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("3ms ch%0d tick count", c), cnt_t[c], 3);
            chk($sformatf("3ms ch%0d first tick", c), first_t[c], 26_999);
            chk($sformatf("3ms ch%0d tick span", c), last_t[c] - first_t[c], 54_000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/module_freq_div_multi.md
Name: module_freq_div_multi

Overview:
Parametrised multi-channel programmable clock divider, successor to the fixed single-output divider on the 27 MHz board clock. Each channel has a runtime-loadable divisor, an enable, and a selectable square-wave or single-pulse mode. Each channel drives a registered divided clock-enable waveform plus a one-cycle tick. Feeds display multiplexing, debounce sampling and timers that need independent rates.

Parameters:
CLK_FREQ_HZ, 27_000_000, input clock frequency; informational, used to derive DEFAULT_DIV.
N_CH, 2, number of independent channels (1..8).
DIV_W, 25, divisor/counter width in bits.
DEFAULT_DIV, 27_000, divisor loaded on reset (1 kHz at 27 MHz).

Ports:
clk  in  1  system clock, 27 MHz.
rst  in  1  synchronous, active-high reset.
en  in  N_CH  per-channel count enable.
mode  in  N_CH  per-channel mode: 0 = square wave, 1 = pulse.
load  in  N_CH  per-channel single-cycle divisor load strobe.
div_val  in  N_CH*DIV_W  divisor for channel i at bits [i*DIV_W +: DIV_W].
clk_out  out  N_CH  divided waveform per channel (registered).
tick  out  N_CH  one-cycle pulse at end of each output period (registered).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No internally generated clocks: clk_out is a logic signal and must not drive clock pins.
- Reset (rst=1 at a clk edge): every channel sets cnt=0, div_reg=DEFAULT_DIV, clk_out=0, tick=0. Reset overrides load and en. Reset asserted mid-period discards progress.
- Effective divisor D = max(div_reg, 2). div_reg values 0 and 1 are clamped to 2, so the fastest output is clk/2.
- Counter per channel: cnt runs 0..D-1. When en=1, cnt advances by 1 per edge. When cnt==D-1, it wraps to 0 on the next enabled edge. When en=0, cnt, clk_out and tick all hold, except that tick is forced to 0.
- Outputs are registered from the next-state counter value, so they align with cnt and have zero extra latency relative to it.
- Square mode (mode=0): clk_out = (cnt >= D>>1).
  - Low phase lasts floor(D/2) cycles; high phase lasts ceil(D/2) cycles.
  - Period is exactly D cycles.
- Pulse mode (mode=1): clk_out = (cnt == D-1), i.e. one cycle high per period.
- tick = 1 for exactly one cycle when cnt==D-1 and en=1, in both modes.
- Load (load[i]=1 at an edge):
  - div_reg[i] <= div_val slice; cnt[i] <= 0; clk_out[i] <= 0; tick[i] <= 0.
  - Load wins over en. The new period starts counting on the following enabled edge.
- Divisor change without load has no effect: div_val is sampled only on load.
- Mode change mid-period takes effect on the next edge using the current cnt, with no counter restart. A glitch-free result is not required.
- If div_reg shrinks below cnt, that can only happen via load, which zeroes cnt, so it cannot occur. The comparator uses cnt >= D-1 as the wrap condition for safety.
- Channels are fully independent. No shared state except clk/rst.
- Arithmetic: all unsigned, DIV_W bits. D>>1 is computed combinationally from div_reg; no divider is inferred.

Decomposition:
- Package freq_div_pkg: MIN_DIV = 2, MODE_SQUARE = 1'b0, MODE_PULSE = 1'b1, default DIV_W, and a clamp function returning max(d, MIN_DIV).
- Sub-module freq_div_channel holds cnt, div_reg and the output registers for one channel. It is instantiated N_CH times in a generate loop; the top level only slices buses.

Test Plan:
- After rst, ch0 load div_val=4, mode=0, en=1 -> clk_out 0,0,1,1 repeating; tick high only in each 4th cycle, cnt==3.
- ch1 div_val=5, mode=0 -> low 2 cycles, high 3 cycles, period 5. Same divisor with mode=1 -> clk_out high 1 cycle in 5, coincident with tick.
- div_val=0 and div_val=1 loaded -> both behave as D=2: clk_out toggles every cycle, tick every 2nd cycle.
- D=10 running: load D=6 at cnt=7 -> next cycle cnt=0, clk_out=0, tick=0, then a clean 6-cycle period. Drop en for 5 cycles at cnt=3 -> outputs frozen, tick=0, resume from cnt=4.
- Reset mid-period (rst at cnt=8, D=10) -> next cycle all outputs 0, div_reg=27000. Run 3 ms at 27 MHz -> exactly 3 ticks per channel, 1 ms spacing (±1 cycle of start offset).
- Channels independent: ch0 D=3, ch1 D=7 with ch1 en toggling -> ch0 waveform unaffected; ch1 tick count matches enabled cycles / 7.
